uart1_rx: RTL and testbench

- Serial receiver for the UART1 link.
- Sits directly downstream of the UART1 transmitter and consumes its serial line.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (parity bit = XOR of the 8 data bits), 1 stop bit (1). Line idles at 1.
- Presents each received byte as a one-cycle valid pulse with parity and framing status.

---
 rtl/uart1_rx.sv | 124 ++++++++++++
 tb/tb_uart1_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart1_rx.sv
// UART1 serial receiver: start, 8 data bits LSB first, even parity, one stop bit.
// Each completed frame is reported with a one-cycle rx_valid pulse and held status flags.
module uart1_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a 0 to mark a start bit
  // START  | timing out the remainder of the start bit, false-start check at mid-bit
  // DATA   | sampling the 8 data bits, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit and publishing the frame
  // BREAK  | line held low after a bad stop bit; wait for it to return high

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic          par_bit, par_nx;
  logic          done;
  logic          at_half, at_last;

  assign at_half = (cnt == HALF);
  assign at_last = (cnt == LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      par_bit  <= par_nx;
      rx_valid <= done;
      if (done) begin
        rx_data    <= shift;
        parity_err <= par_bit ^ (^shift);
        frame_err  <= ~serial_in;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = at_last ? '0 : cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    par_nx     = par_bit;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!serial_in) begin
          // With one clock per bit the start bit is already over, so the counter
          // restarts at 0 for the first data bit instead of counting on.
          cnt_nx     = (CLKS_PER_BIT == 1) ? '0 : CW'(1);
          bit_cnt_nx = '0;
          state_nx   = (CLKS_PER_BIT == 1) ? DATA : START;
        end
      end
      START: begin
        if (HALF != '0 && at_half && serial_in) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (at_last) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
        end
      end
      DATA: begin
        if (at_half) shift_nx = {serial_in, shift[7:1]};
        if (at_last) begin
          if (bit_cnt == 4'd7) state_nx = PARITY;
          else                 bit_cnt_nx = bit_cnt + 4'd1;
        end
      end
      PARITY: begin
        if (at_half) par_nx = serial_in;
        if (at_last) state_nx = STOP;
      end
      STOP: begin
        if (at_half) begin
          done     = 1'b1;
          cnt_nx   = '0;
          state_nx = serial_in ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_nx = '0;
        if (serial_in) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart1_rx.sv
// Bench for uart1_rx: one receiver at 1 clk/bit and one at 4 clk/bit, directed plus random frames.
// Expected frame results and their arrival cycles come from the frame contents and bit timing.
module tb_uart1_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser0 = 1'b1, ser1 = 1'b1;
  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;
  int unsigned cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
  } ev_t;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] hd[2];
  logic       hpe[2];
  logic       hfe[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart1_rx #(.CLKS_PER_BIT(1)) u_m1 (
    .clk(clk), .rst(rst), .serial_in(ser0), .rx_data(d0), .rx_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );

  uart1_rx #(.CLKS_PER_BIT(4)) u_m4 (
    .clk(clk), .rst(rst), .serial_in(ser1), .rx_data(d1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mval(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic mon(input int i, input logic v, input logic [7:0] d, input logic pe, input logic fe);
    ev_t e;
    bit  have;
    have = 1'b0;
    e    = '{cyc: 0, d: 8'h00, pe: 1'b0, fe: 1'b0};
    if (v === 1'b1) begin
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      else if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) chk($sformatf("spurious_valid_m%0d", mval(i)), v, 0);
      else begin
        chk($sformatf("valid_cycle_m%0d", mval(i)), cyc, e.cyc);
        chk($sformatf("rx_data_m%0d", mval(i)), d, e.d);
        chk($sformatf("parity_err_m%0d", mval(i)), pe, e.pe);
        chk($sformatf("frame_err_m%0d", mval(i)), fe, e.fe);
        hd[i]  = e.d;
        hpe[i] = e.pe;
        hfe[i] = e.fe;
      end
    end else begin
      chk($sformatf("hold_valid_m%0d", mval(i)), v, 0);
      chk($sformatf("hold_data_m%0d", mval(i)), d, hd[i]);
      chk($sformatf("hold_perr_m%0d", mval(i)), pe, hpe[i]);
      chk($sformatf("hold_ferr_m%0d", mval(i)), fe, hfe[i]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, v0, d0, pe0, fe0);
    mon(1, v1, d1, pe1, fe1);
  end

  // Entered and left at a falling edge; each call holds the line for n cycles.
  task automatic drive(input int i, input logic val, input int n);
    repeat (n) begin
      if (i == 0) ser0 = val;
      else        ser1 = val;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input logic par, input logic stp);
    int         m;
    ev_t        e;
    logic [10:0] fr;
    m     = mval(i);
    e.cyc = cyc + 10 * m + (m - 1) / 2 + 1;
    e.d   = d;
    e.pe  = par ^ (^d);
    e.fe  = ~stp;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    fr = {stp, par, d, 1'b0};
    for (int k = 0; k < 11; k++) drive(i, fr[k], m);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      hd[i]  = 8'h00;
      hpe[i] = 1'b0;
      hfe[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int          c;
    logic [7:0]  rd;
    logic        pc, sb;
    logic [10:0] fr;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    chk("reset_data_m1", d0, 0);
    chk("reset_valid_m1", v0, 0);
    chk("reset_perr_m1", pe0, 0);
    chk("reset_ferr_m1", fe0, 0);
    chk("reset_busy_m1", b0, 0);
    chk("reset_data_m4", d1, 0);
    chk("reset_busy_m4", b1, 0);
    rst = 1'b0;
    drive(0, 1'b1, 3);

    send_frame(0, 8'hA5, 1'b0, 1'b1);
    drive(0, 1'b1, 3);
    chk("busy_after_a5", b0, 0);
    chk("pending_a5", q0.size(), 0);

    send_frame(0, 8'h07, 1'b1, 1'b1);
    send_frame(0, 8'h80, 1'b1, 1'b1);
    drive(0, 1'b1, 3);
    chk("pending_b2b", q0.size(), 0);

    send_frame(0, 8'h07, 1'b0, 1'b1);
    drive(0, 1'b1, 5);
    chk("perr_held", pe0, 1);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    drive(0, 1'b1, 3);
    chk("perr_cleared", pe0, 0);

    send_frame(0, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b0, 1);
      chk("busy_in_break", b0, 1);
    end
    drive(0, 1'b1, 1);
    chk("busy_after_break", b0, 0);
    drive(0, 1'b1, 2);
    chk("pending_break", q0.size(), 0);

    c = cyc;
    drive(1, 1'b0, 1);
    chk("busy_glitch_c1", b1, 1);
    drive(1, 1'b1, 1);
    chk("busy_glitch_c2", b1, 0);
    chk("glitch_cycle", cyc - c, 2);
    drive(1, 1'b1, 4);
    send_frame(1, 8'h5A, 1'b0, 1'b1);
    drive(1, 1'b1, 6);
    chk("pending_m4_5a", q1.size(), 0);

    // Abort a frame inside data bit 4, then resend cleanly.
    fr = {1'b1, 1'b1, 8'h6B, 1'b0};
    for (int k = 0; k < 5; k++) drive(0, fr[k], 1);
    ser0 = fr[5];
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("rst_mid_data", d0, 0);
    chk("rst_mid_valid", v0, 0);
    chk("rst_mid_perr", pe0, 0);
    chk("rst_mid_ferr", fe0, 0);
    chk("rst_mid_busy", b0, 0);
    chk("rst_mid_data_m4", d1, 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    drive(0, 1'b1, 2);
    send_frame(0, 8'h11, 1'b0, 1'b1);
    drive(0, 1'b1, 3);
    chk("pending_after_rst", q0.size(), 0);

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < ((i == 0) ? 40 : 15); n++) begin
        rd = 8'($urandom);
        pc = ($urandom_range(0, 3) == 0);
        sb = ($urandom_range(0, 4) != 0);
        send_frame(i, rd, (^rd) ^ pc, sb);
        if (!sb) drive(i, 1'b0, $urandom_range(0, 3));
        drive(i, 1'b1, sb ? $urandom_range(0, 2) : $urandom_range(1, 3));
      end
      drive(i, 1'b1, 4);
      chk("busy_after_random", (i == 0) ? b0 : b1, 0);
      chk("pending_random", (i == 0) ? q0.size() : q1.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
